apb_master: RTL and testbench

Single-outstanding APB master bridging a simple valid/ready command/response interface onto the APB bus that feeds the APB slave/register-file subsystem. Each accepted command is run as one APB SETUP/ACCESS transfer. PSEL is decoded one-hot from the top two address bits. The master waits on PREADY with a bounded timeout and returns read data plus an error flag on a response channel.

---
 rtl/apb_master_if.sv | 39 +++
 rtl/apb_master.sv | 118 +++++++++++
 tb/tb_apb_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response and APB signal bundle for apb_master
interface apb_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   // command channel
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   // response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   // APB bus
   logic [3:0]            PSEL;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   // status
   logic                  busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, busy
   );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master with PREADY timeout
module apb_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic          PCLK_i,
   input  logic          PRESET_i,
   apb_master_if.master  bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                state_q;
   logic [3:0]            psel_q;
   logic                  penable_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  busy_q;
   logic [CW-1:0]         cnt_q;

   // top two address bits pick one of four slaves
   function automatic logic [3:0] decode_sel(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

   // transfer sequencer: every APB and response output is a register written here
   always_ff @(posedge PCLK_i) begin
      if (PRESET_i) begin
         state_q     <= S_IDLE;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  paddr_q   <= bus.cmd_addr;
                  pwrite_q  <= bus.cmd_write;
                  pwdata_q  <= bus.cmd_wdata;
                  psel_q    <= decode_sel(bus.cmd_addr[ADDR_WIDTH-1 -: 2]);
                  penable_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_SETUP;
               end
            end
            S_SETUP: begin
               // PREADY is deliberately not looked at during the setup phase
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               // PREADY is checked first so a slave answering on the last allowed cycle still wins
               if (bus.PREADY) begin
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESP: begin
               // response is parked until consumed; the next command waits for IDLE
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - table-driven scoreboard bench for apb_master
module tb_apb_master;

   localparam int DW      = 32;
   localparam int AW      = 16;
   localparam int TIMEOUT = 16;

   logic clk;
   logic rst;

   apb_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   apb_master #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .PCLK_i  (clk),
      .PRESET_i(rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            wait_n;
      logic [DW-1:0] prdata;
      int            hold;
      logic [3:0]    exp_psel;
      int            exp_access;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
   } rsp_t;

   rsp_t sb[$];
   vec_t vecs[7];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus_invariants(input string tag);
      chk({tag, ":penable_without_psel"}, DW'(bus.PENABLE && (bus.PSEL == 4'b0)), '0);
      chk({tag, ":psel_onehot"}, DW'($countones(bus.PSEL) > 1), '0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ":psel"},      DW'(bus.PSEL), '0);
      chk({tag, ":penable"},   DW'(bus.PENABLE), '0);
      chk({tag, ":paddr"},     DW'(bus.PADDR), '0);
      chk({tag, ":pwrite"},    DW'(bus.PWRITE), '0);
      chk({tag, ":pwdata"},    bus.PWDATA, '0);
      chk({tag, ":rsp_valid"}, DW'(bus.rsp_valid), '0);
      chk({tag, ":rsp_rdata"}, bus.rsp_rdata, '0);
      chk({tag, ":rsp_err"},   DW'(bus.rsp_err), '0);
      chk({tag, ":busy"},      DW'(bus.busy), '0);
      chk({tag, ":cmd_ready"}, DW'(bus.cmd_ready), 32'd1);
   endtask

   // issues one command from a negedge with the DUT idle and returns at a negedge with it idle again
   task automatic run_vec(input vec_t v, input string tag);
      rsp_t          e;
      rsp_t          g;
      int            cyc;
      int            acc;
      bit            done;
      logic [DW-1:0] rd_hold;

      chk({tag, ":cmd_ready_idle"}, DW'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.rsp_ready = (v.hold == 0);
      bus.PREADY    = 1'b0;
      e.err   = v.exp_err;
      e.rdata = v.exp_rdata;
      sb.push_back(e);

      @(negedge clk);
      cyc = 1;
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = ~v.wdata;
      chk({tag, ":setup_psel"},    DW'(bus.PSEL), DW'(v.exp_psel));
      chk({tag, ":setup_penable"}, DW'(bus.PENABLE), '0);
      chk({tag, ":setup_paddr"},   DW'(bus.PADDR), DW'(v.addr));
      chk({tag, ":setup_pwrite"},  DW'(bus.PWRITE), DW'(v.wr));
      chk({tag, ":setup_pwdata"},  bus.PWDATA, v.wdata);
      chk({tag, ":setup_busy"},    DW'(bus.busy), 32'd1);
      chk({tag, ":setup_cmd_ready"}, DW'(bus.cmd_ready), '0);

      acc  = 0;
      done = 1'b0;
      for (int i = 0; i < TIMEOUT + 8 && !done; i++) begin
         @(negedge clk);
         cyc++;
         bus_invariants(tag);
         if (bus.PENABLE) begin
            acc++;
            if (bus.PSEL !== v.exp_psel || bus.PADDR !== v.addr || bus.PWDATA !== v.wdata) begin
               chk({tag, ":access_stable_psel"}, DW'(bus.PSEL), DW'(v.exp_psel));
               chk({tag, ":access_stable_paddr"}, DW'(bus.PADDR), DW'(v.addr));
               chk({tag, ":access_stable_pwdata"}, bus.PWDATA, v.wdata);
            end
            if (acc == v.wait_n + 1) begin
               bus.PREADY = 1'b1;
               bus.PRDATA = v.prdata;
            end else begin
               bus.PREADY = 1'b0;
               bus.PRDATA = ~v.prdata;
            end
         end else begin
            bus.PREADY = 1'b0;
            if (bus.rsp_valid) done = 1'b1;
         end
      end

      if (!done) begin
         chk({tag, ":rsp_never_arrived"}, '0, 32'd1);
         return;
      end

      chk({tag, ":access_cycles"}, DW'(acc), DW'(v.exp_access));
      chk({tag, ":rsp_latency"},   DW'(cyc), DW'(2 + v.exp_access));
      chk({tag, ":rsp_psel"},      DW'(bus.PSEL), '0);
      chk({tag, ":rsp_penable"},   DW'(bus.PENABLE), '0);
      if (sb.size() == 0) begin
         chk({tag, ":scoreboard_empty"}, '0, 32'd1);
      end else begin
         g = sb.pop_front();
         chk({tag, ":rsp_err"},   DW'(bus.rsp_err), DW'(g.err));
         chk({tag, ":rsp_rdata"}, bus.rsp_rdata, g.rdata);
      end

      rd_hold = bus.rsp_rdata;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk({tag, ":bp_rsp_valid"}, DW'(bus.rsp_valid), 32'd1);
         chk({tag, ":bp_rdata"},     bus.rsp_rdata, rd_hold);
         chk({tag, ":bp_cmd_ready"}, DW'(bus.cmd_ready), '0);
         chk({tag, ":bp_psel"},      DW'(bus.PSEL), '0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, ":post_rsp_valid"}, DW'(bus.rsp_valid), '0);
      chk({tag, ":post_cmd_ready"}, DW'(bus.cmd_ready), 32'd1);
      chk({tag, ":post_busy"},      DW'(bus.busy), '0);
   endtask

   initial begin
      vec_t v;

      //         wr    addr       wdata          wait prdata         hold psel     acc err  rdata
      vecs[0] = '{1'b1, 16'h0040, 32'hDEADBEEF,  0,  32'hFFFFFFFF,  0,   4'b0001, 1,  1'b0, 32'h0};
      vecs[1] = '{1'b0, 16'h8100, 32'h0,         3,  32'h12345678,  0,   4'b0100, 4,  1'b0, 32'h12345678};
      vecs[2] = '{1'b0, 16'hC000, 32'h0,         100, 32'h55555555, 0,   4'b1000, 16, 1'b1, 32'h0};
      vecs[3] = '{1'b0, 16'hC000, 32'h0,         15, 32'h0BADF00D,  0,   4'b1000, 16, 1'b0, 32'h0BADF00D};
      vecs[4] = '{1'b0, 16'h4004, 32'h0,         0,  32'hA5A5A5A5,  5,   4'b0010, 1,  1'b0, 32'hA5A5A5A5};
      vecs[5] = '{1'b1, 16'h7FFC, 32'hCAFEF00D,  2,  32'hFFFFFFFF,  1,   4'b0010, 3,  1'b0, 32'h0};
      vecs[6] = '{1'b1, 16'hFFFF, 32'h00000001,  14, 32'h11111111,  0,   4'b1000, 15, 1'b0, 32'h0};

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      bus.PREADY    = 1'b0;
      bus.PRDATA    = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 7; k++) begin
         run_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // reset lands in the middle of a waited read: nothing may come back
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 16'h4010;
      bus.cmd_wdata = 32'h77777777;
      bus.rsp_ready = 1'b1;
      bus.PREADY    = 1'b0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst:in_access", DW'(bus.PENABLE), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("midrst:no_rsp", DW'(bus.rsp_valid), '0);
         chk("midrst:no_psel", DW'(bus.PSEL), '0);
      end

      v = '{1'b1, 16'h0000, 32'h00000001, 0, 32'hFFFFFFFF, 0, 4'b0001, 1, 1'b0, 32'h0};
      run_vec(v, "after_rst");

      chk("scoreboard_drained", DW'(sb.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
